// File: rtl/rf_write_arbiter_pkg.sv
// Shared register-file constants for the writeback arbiter and its FIFO.
`ifndef RF_WRITE_ARBITER_PKG_SV
`define RF_WRITE_ARBITER_PKG_SV

package rf_write_arbiter_pkg;

    localparam int unsigned RF_ADDR_W   = 5;
    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_ZERO_REG = 0;

endpackage

`endif

// File: rtl/rf_write_arbiter_wb_fifo2.sv
// Two-entry FIFO of {rd, data} writeback entries; entry 0 is always the head.
module wb_fifo2 #(
    parameter int unsigned W = 37
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] e0_q, e1_q;
    logic [W-1:0] e0_d, e1_d;
    logic         e0_en, e1_en;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign count   = cnt_q;
    assign dout    = e0_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Entry enables: a pop shifts entry 1 into the head, a push fills the first free slot.
    always_comb begin
        e0_en = 1'b0;
        e1_en = 1'b0;
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (do_push && do_pop) begin
            if (cnt_q == 2'd1) begin
                e0_en = 1'b1;
                e0_d  = din;
            end else begin
                e0_en = 1'b1;
                e0_d  = e1_q;
                e1_en = 1'b1;
                e1_d  = din;
            end
        end else if (do_pop) begin
            e0_en = 1'b1;
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
        end else if (do_push) begin
            if (cnt_q == 2'd0) begin
                e0_en = 1'b1;
                e0_d  = din;
            end else begin
                e1_en = 1'b1;
                e1_d  = din;
            end
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (e0_en) e0_q <= e0_d;
            if (e1_en) e1_q <= e1_d;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback (P)
// and a buffered multi-cycle unit (M), with starvation-bounded P priority.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_valid,
    input  logic [ADDR_W-1:0] p_rd,
    input  logic [DATA_W-1:0] p_data,
    output logic              p_ready,
    input  logic              m_valid,
    input  logic [ADDR_W-1:0] m_rd,
    input  logic [DATA_W-1:0] m_data,
    output logic              m_ready,
    output logic [1:0]        m_count,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_data
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);

    logic [ENTRY_W-1:0] head;
    logic               fifo_full, fifo_empty;
    logic               m_push;
    logic               force_m, p_uses_port;
    logic               grant_p, grant_m;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;

    assign m_ready     = ~fifo_full;
    assign m_push      = m_valid & m_ready & (m_rd != ADDR_W'(RF_ZERO_REG));
    assign force_m     = ~fifo_empty & (wait_cnt == WAIT_W'(MAX_WAIT));
    assign p_uses_port = p_valid & (p_rd != ADDR_W'(RF_ZERO_REG));

    wb_fifo2 #(.W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (m_push),
        .pop   (grant_m),
        .din   ({m_rd, m_data}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (m_count)
    );

    // Grant selection; an r0 write from P never occupies the port.
    always_comb begin
        grant_p = 1'b0;
        grant_m = 1'b0;
        p_ready = 1'b1;
        if (force_m) begin
            grant_m = 1'b1;
            p_ready = (p_rd == ADDR_W'(RF_ZERO_REG));
        end else if (p_uses_port) begin
            grant_p = 1'b1;
        end else if (!fifo_empty) begin
            grant_m = 1'b1;
        end
    end

    // Starvation counter: counts P grants that bypass a waiting M head.
    always_comb begin
        wait_nxt = wait_cnt;
        if (grant_m || fifo_empty) begin
            wait_nxt = '0;
        end else if (grant_p && (wait_cnt != WAIT_W'(MAX_WAIT))) begin
            wait_nxt = wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            rf_write <= 1'b0;
            rf_rd    <= '0;
            rf_data  <= '0;
        end else begin
            wait_cnt <= wait_nxt;
            rf_write <= grant_p | grant_m;
            if (grant_p) begin
                rf_rd   <= p_rd;
                rf_data <= p_data;
            end else if (grant_m) begin
                rf_rd   <= head[DATA_W +: ADDR_W];
                rf_data <= head[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter with default parameters.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_valid;
    logic [4:0]  p_rd;
    logic [31:0] p_data;
    logic        p_ready;
    logic        m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_ready;
    logic [1:0]  m_count;
    logic        rf_write;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .p_valid  (p_valid),
        .p_rd     (p_rd),
        .p_data   (p_data),
        .p_ready  (p_ready),
        .m_valid  (m_valid),
        .m_rd     (m_rd),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .m_count  (m_count),
        .rf_write (rf_write),
        .rf_rd    (rf_rd),
        .rf_data  (rf_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
        chk({tag, ".write"}, 64'(rf_write), 64'd1);
        chk({tag, ".rd"},    64'(rf_rd),    64'(rd));
        chk({tag, ".data"},  64'(rf_data),  64'(data));
    endtask

    initial begin
        reset   = 1'b1;
        p_valid = 1'b0; p_rd = '0; p_data = '0;
        m_valid = 1'b0; m_rd = '0; m_data = '0;
        tick();
        tick();
        chk("rst.write", 64'(rf_write), 64'd0);
        chk("rst.rd",    64'(rf_rd),    64'd0);
        chk("rst.data",  64'(rf_data),  64'd0);
        chk("rst.count", 64'(m_count),  64'd0);
        reset = 1'b0;
        #1;
        chk("rst.m_ready", 64'(m_ready), 64'd1);
        chk("rst.p_ready", 64'(p_ready), 64'd1);
        tick();

        // P only
        p_valid = 1'b1; p_rd = 5'd3; p_data = 32'hDEADBEEF;
        #1 chk("p.ready", 64'(p_ready), 64'd1);
        tick();
        chk_wr("p.wr", 5'd3, 32'hDEADBEEF);
        p_valid = 1'b0;
        #1 chk("p.ready_idle", 64'(p_ready), 64'd1);
        tick();
        chk("p.no_wr", 64'(rf_write), 64'd0);
        chk("p.hold_rd", 64'(rf_rd), 64'd3);

        // M only: the head is granted the cycle after each push, so occupancy stays at 1
        m_valid = 1'b1; m_rd = 5'd7; m_data = 32'h11;
        #1 chk("m.ready0", 64'(m_ready), 64'd1);
        tick();
        chk("m.count_a", 64'(m_count), 64'd1);
        chk("m.no_wr", 64'(rf_write), 64'd0);
        m_rd = 5'd8; m_data = 32'h22;
        #1 chk("m.ready1", 64'(m_ready), 64'd1);
        tick();
        chk("m.count_b", 64'(m_count), 64'd1);
        chk_wr("m.wr7", 5'd7, 32'h11);
        m_valid = 1'b0;
        tick();
        chk("m.count_c", 64'(m_count), 64'd0);
        chk_wr("m.wr8", 5'd8, 32'h22);
        tick();
        chk("m.idle", 64'(rf_write), 64'd0);

        // Starvation: one M entry vs continuous P writes to r1
        p_valid = 1'b1; p_rd = 5'd1; p_data = 32'h100;
        m_valid = 1'b1; m_rd = 5'd9; m_data = 32'h99;
        tick();
        m_valid = 1'b0;
        chk_wr("s.p0", 5'd1, 32'h100);
        for (int i = 1; i <= 4; i++) begin
            p_data = 32'h100 + 32'(i);
            #1 chk("s.p_ready", 64'(p_ready), 64'd1);
            tick();
            chk_wr("s.pwr", 5'd1, 32'h100 + 32'(i));
        end
        p_data = 32'h200;
        #1 chk("s.stall", 64'(p_ready), 64'd0);
        tick();
        chk_wr("s.forced", 5'd9, 32'h99);
        chk("s.count0", 64'(m_count), 64'd0);
        #1 chk("s.resume", 64'(p_ready), 64'd1);
        tick();
        chk_wr("s.presume", 5'd1, 32'h200);
        p_valid = 1'b0;
        tick();

        // Full FIFO under continuous P traffic on r2
        p_valid = 1'b1; p_rd = 5'd2; p_data = 32'h2;
        m_valid = 1'b1; m_rd = 5'd10; m_data = 32'hA0;
        tick();
        m_rd = 5'd11; m_data = 32'hB0;
        #1 chk("f.ready1", 64'(m_ready), 64'd1);
        chk("f.count1", 64'(m_count), 64'd1);
        tick();
        m_rd = 5'd12; m_data = 32'hC0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("f.full_ready", 64'(m_ready), 64'd0);
            chk("f.full_count", 64'(m_count), 64'd2);
            chk("f.p_ready", 64'(p_ready), 64'd1);
            tick();
            chk_wr("f.pwr", 5'd2, 32'h2);
        end
        #1 chk("f.force_ready", 64'(m_ready), 64'd0);
        chk("f.force_stall", 64'(p_ready), 64'd0);
        chk("f.force_count", 64'(m_count), 64'd2);
        tick();
        chk_wr("f.wr10", 5'd10, 32'hA0);
        chk("f.count_after", 64'(m_count), 64'd1);
        #1 chk("f.ready_again", 64'(m_ready), 64'd1);
        chk("f.p_ready2", 64'(p_ready), 64'd1);
        tick();
        chk_wr("f.pwr2", 5'd2, 32'h2);
        chk("f.count_c", 64'(m_count), 64'd2);
        p_valid = 1'b0; m_valid = 1'b0;
        tick();
        chk_wr("f.wr11", 5'd11, 32'hB0);
        tick();
        chk_wr("f.wr12", 5'd12, 32'hC0);
        chk("f.drained", 64'(m_count), 64'd0);

        // r0 filtering
        p_valid = 1'b1; p_rd = 5'd0; p_data = 32'hBAD;
        m_valid = 1'b1; m_rd = 5'd4; m_data = 32'h44;
        #1 chk("z.p_ready0", 64'(p_ready), 64'd1);
        tick();
        m_valid = 1'b0;
        chk("z.no_wr", 64'(rf_write), 64'd0);
        chk("z.count1", 64'(m_count), 64'd1);
        #1 chk("z.p_ready1", 64'(p_ready), 64'd1);
        tick();
        chk_wr("z.wr4", 5'd4, 32'h44);
        chk("z.count0", 64'(m_count), 64'd0);
        p_valid = 1'b0;
        m_valid = 1'b1; m_rd = 5'd0; m_data = 32'h55;
        #1 chk("z.m_ready", 64'(m_ready), 64'd1);
        tick();
        m_valid = 1'b0;
        chk("z.m_r0_count", 64'(m_count), 64'd0);
        chk("z.m_r0_nowr", 64'(rf_write), 64'd0);
        tick();
        chk("z.m_r0_nowr2", 64'(rf_write), 64'd0);

        // Mid-operation reset with two entries queued and wait_cnt at 3
        p_valid = 1'b1; p_rd = 5'd5; p_data = 32'h5;
        m_valid = 1'b1; m_rd = 5'd13; m_data = 32'hD0;
        tick();
        m_rd = 5'd14; m_data = 32'hE0;
        tick();
        m_valid = 1'b0;
        tick();
        tick();
        chk("r.count2", 64'(m_count), 64'd2);
        chk_wr("r.pwr", 5'd5, 32'h5);
        reset = 1'b1;
        tick();
        chk("r.write", 64'(rf_write), 64'd0);
        chk("r.rd",    64'(rf_rd),    64'd0);
        chk("r.data",  64'(rf_data),  64'd0);
        chk("r.count", 64'(m_count),  64'd0);
        reset = 1'b0; p_valid = 1'b0;
        #1 chk("r.m_ready", 64'(m_ready), 64'd1);
        chk("r.p_ready", 64'(p_ready), 64'd1);
        tick();
        chk("r.no_wr", 64'(rf_write), 64'd0);
        chk("r.count_post", 64'(m_count), 64'd0);
        tick();
        chk("r.no_wr2", 64'(rf_write), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
